// File: rtl/game_pkg.sv
// Shared game-area constants, row-word type and board FSM states.
// The renderer uses the same row/column constants.
package game_pkg;

    localparam int unsigned GAME_ROWS  = 20;
    localparam int unsigned GAME_COLS  = 12;
    localparam int unsigned GAME_ROW_W = 5;

    typedef logic [GAME_COLS-1:0] row_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FILL,
        ST_DONE,
        ST_WIPE
    } area_state_t;

endpackage

// File: rtl/game_area_compactor.sv
// Board FSM: line-clear compaction (SCAN/FILL, built only with GAME_AREA_LINE_CLEAR_EN)
// and whole-board wipe; drives the row write-enable/select for the board array.
module game_area_compactor
    import game_pkg::*;
#(
    parameter int unsigned ROWS = GAME_ROWS
) (
    input  logic                  vga_clk,
    input  logic                  rst,
    input  logic                  clear_req,
    input  logic                  wipe_req,
    input  logic                  src_full,
    output logic                  idle,
    output logic                  busy,
    output logic                  clear_done,
    output logic [2:0]            lines_cleared,
    output logic                  row_we,
    output logic                  row_zero,
    output logic [GAME_ROW_W-1:0] row_sel,
    output logic [GAME_ROW_W-1:0] src_sel
);

    localparam int unsigned           LAST     = ROWS - 1;
    localparam logic [GAME_ROW_W-1:0] LAST_ROW = LAST[GAME_ROW_W-1:0];

    area_state_t           state;
    logic [GAME_ROW_W-1:0] src;
`ifdef GAME_AREA_LINE_CLEAR_EN
    logic [GAME_ROW_W-1:0] dst;
    logic [2:0]            count;
`else
    logic                  unused_src_full;
    assign unused_src_full = src_full;
`endif

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            src           <= '0;
`ifdef GAME_AREA_LINE_CLEAR_EN
            dst           <= '0;
            count         <= '0;
`endif
            busy          <= 1'b0;
            clear_done    <= 1'b0;
            lines_cleared <= '0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wipe_req) begin
                        state <= ST_WIPE;
                        src   <= '0;
                        busy  <= 1'b1;
                    end else if (clear_req) begin
`ifdef GAME_AREA_LINE_CLEAR_EN
                        state <= ST_SCAN;
                        src   <= LAST_ROW;
                        dst   <= LAST_ROW;
                        count <= '0;
                        busy  <= 1'b1;
`else
                        state         <= ST_DONE;
                        clear_done    <= 1'b1;
                        lines_cleared <= '0;
`endif
                    end
                end
`ifdef GAME_AREA_LINE_CLEAR_EN
                ST_SCAN: begin
                    if (src_full) begin
                        if (count != 3'd7) count <= count + 3'd1;
                    end else begin
                        dst <= dst - 1'b1;
                    end
                    src <= src - 1'b1;
                    // count is not yet updated for the row being scanned this cycle
                    if (src == '0) begin
                        if (src_full || count != '0) begin
                            state <= ST_FILL;
                        end else begin
                            state         <= ST_DONE;
                            busy          <= 1'b0;
                            clear_done    <= 1'b1;
                            lines_cleared <= '0;
                        end
                    end
                end
                ST_FILL: begin
                    dst <= dst - 1'b1;
                    if (dst == '0) begin
                        state         <= ST_DONE;
                        busy          <= 1'b0;
                        clear_done    <= 1'b1;
                        lines_cleared <= count;
                    end
                end
`endif
                ST_DONE: state <= ST_IDLE;
                ST_WIPE: begin
                    src <= src + 1'b1;
                    if (src == LAST_ROW) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        row_we   = 1'b0;
        row_zero = 1'b1;
        row_sel  = src;
        case (state)
`ifdef GAME_AREA_LINE_CLEAR_EN
            ST_SCAN: begin
                row_we   = !src_full;
                row_zero = 1'b0;
                row_sel  = dst;
            end
            ST_FILL: begin
                row_we  = 1'b1;
                row_sel = dst;
            end
`endif
            ST_WIPE: row_we = 1'b1;
            default: ;
        endcase
    end

    assign src_sel = src;
    assign idle    = (state == ST_IDLE);

endmodule

// File: rtl/game_area_store.sv
// Game-area board storage with the renderer's registered row-read port.
// Line-clear compaction is built only when GAME_AREA_LINE_CLEAR_EN is defined.
module game_area_store
    import game_pkg::*;
#(
    parameter int unsigned ROWS = GAME_ROWS,
    parameter int unsigned COLS = GAME_COLS
) (
    input  logic            vga_clk,
    input  logic            rst,
    input  logic [4:0]      game_area_addr,
    output logic [COLS-1:0] game_area_data,
    input  logic            wr_en,
    input  logic [4:0]      wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic            wr_merge,
    input  logic            clear_req,
    input  logic            wipe_req,
    output logic            busy,
    output logic            clear_done,
    output logic [2:0]      lines_cleared
);

    logic [COLS-1:0] board [ROWS];

    logic       idle;
    logic       row_we;
    logic       row_zero;
    logic [4:0] row_sel;
    logic [4:0] src_sel;
    logic       src_full;

    assign src_full = (board[src_sel] == '1);

    game_area_compactor #(
        .ROWS(ROWS)
    ) u_compactor (
        .vga_clk      (vga_clk),
        .rst          (rst),
        .clear_req    (clear_req),
        .wipe_req     (wipe_req),
        .src_full     (src_full),
        .idle         (idle),
        .busy         (busy),
        .clear_done   (clear_done),
        .lines_cleared(lines_cleared),
        .row_we       (row_we),
        .row_zero     (row_zero),
        .row_sel      (row_sel),
        .src_sel      (src_sel)
    );

    // FSM row writes and game-logic writes never coincide: the latter are taken only in IDLE
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ROWS; i++) board[i] <= '0;
        end else if (row_we) begin
            board[row_sel] <= row_zero ? '0 : board[src_sel];
        end else if (idle && wr_en && (32'(wr_row) < ROWS)) begin
            board[wr_row] <= wr_merge ? (board[wr_row] | wr_data) : wr_data;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            game_area_data <= '0;
        end else begin
            game_area_data <= (32'(game_area_addr) < ROWS) ? board[game_area_addr] : '0;
        end
    end

endmodule

// File: tb/tb_game_area_store.sv
// Scoreboard bench for game_area_store; expectations follow GAME_AREA_LINE_CLEAR_EN.
module tb_game_area_store;
    import game_pkg::*;

    localparam int ROWS = GAME_ROWS;
    localparam int FULL = 'hFFF;
`ifdef GAME_AREA_LINE_CLEAR_EN
    localparam bit LC_EN = 1'b1;
`else
    localparam bit LC_EN = 1'b0;
`endif

    logic        vga_clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  game_area_addr = '0;
    logic [11:0] game_area_data;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_row = '0;
    logic [11:0] wr_data = '0;
    logic        wr_merge = 1'b0;
    logic        clear_req = 1'b0;
    logic        wipe_req = 1'b0;
    logic        busy;
    logic        clear_done;
    logic [2:0]  lines_cleared;

    game_area_store #(
        .ROWS(GAME_ROWS),
        .COLS(GAME_COLS)
    ) dut (
        .vga_clk       (vga_clk),
        .rst           (rst),
        .game_area_addr(game_area_addr),
        .game_area_data(game_area_data),
        .wr_en         (wr_en),
        .wr_row        (wr_row),
        .wr_data       (wr_data),
        .wr_merge      (wr_merge),
        .clear_req     (clear_req),
        .wipe_req      (wipe_req),
        .busy          (busy),
        .clear_done    (clear_done),
        .lines_cleared (lines_cleared)
    );

    always #5 vga_clk = ~vga_clk;

    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;
    bit     rst_q = 1'b1;
    bit     rd_issue = 1'b0;
    bit     rd_vld = 1'b0;

    // Reference board and timing windows, all in terms of edge numbers
    int     board [ROWS] = '{default: 0};
    longint free_edge = 0;
    longint busy_lo = 1;
    longint busy_hi = 0;
    int     hold_lines = 0;

    typedef struct { longint obs; int lines; } done_t;
    typedef struct { int addr; int data; } rd_t;
    done_t exp_done[$];
    rd_t   exp_rd[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge vga_clk) begin
        cyc    <= cyc + 1;
        rst_q  <= rst;
        rd_vld <= rd_issue;
    end

    // Monitor: compares DUT outputs against queued expectations
    always @(negedge vga_clk) begin
        rd_t   r;
        done_t d;
        check("busy", 64'(busy), 64'((cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0));
        if (rd_vld) begin
            if (exp_rd.size() == 0) begin
                check("read_unexpected", 64'(game_area_data), 64'hDEAD);
            end else begin
                r = exp_rd.pop_front();
                check($sformatf("read_row%0d", r.addr), 64'(game_area_data), 64'(r.data));
            end
        end
        if (rst_q) begin
            exp_done.delete();
            hold_lines = 0;
            check("reset_done", 64'(clear_done), 64'd0);
            check("reset_lines", 64'(lines_cleared), 64'd0);
        end else if (clear_done) begin
            if (exp_done.size() == 0) begin
                check("done_spurious", 64'(clear_done), 64'd0);
            end else begin
                d = exp_done.pop_front();
                check("done_cycle", 64'(cyc), 64'(d.obs));
                check("done_lines", 64'(lines_cleared), 64'(d.lines));
                hold_lines = d.lines;
            end
        end else begin
            if (exp_done.size() > 0 && cyc > exp_done[0].obs) begin
                d = exp_done.pop_front();
                check("done_timeout", 64'(cyc), 64'(d.obs));
            end
            check("lines_hold", 64'(lines_cleared), 64'(hold_lines));
        end
    end

    task automatic model_clear(output int k);
        int kept[$];
        k = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (board[r] == FULL) k++;
            else kept.push_back(board[r]);
        end
        for (int r = ROWS - 1; r >= 0; r--)
            board[r] = ((ROWS - 1 - r) < kept.size()) ? kept[ROWS - 1 - r] : 0;
    endtask

    task automatic drive(input bit we, input int row, input int data, input bit merge,
                         input bit clr, input bit wip, input bit rd, input int raddr);
        longint e;
        bit     idle_now;
        int     k;
        @(negedge vga_clk);
        e        = cyc + 1;
        idle_now = (e >= free_edge);
        rst            = 1'b0;
        wr_en          = we;
        wr_row         = 5'(row);
        wr_data        = 12'(data);
        wr_merge       = merge;
        clear_req      = clr;
        wipe_req       = wip;
        game_area_addr = 5'(raddr);
        rd_issue       = rd && idle_now;
        if (rd_issue) exp_rd.push_back('{addr: raddr, data: (raddr < ROWS) ? board[raddr] : 0});
        if (we && idle_now && row < ROWS) board[row] = merge ? (board[row] | data) : data;
        if (idle_now && wip) begin
            for (int r = 0; r < ROWS; r++) board[r] = 0;
            free_edge = e + ROWS + 1;
            busy_lo   = e;
            busy_hi   = e + ROWS - 1;
        end else if (idle_now && clr) begin
            if (LC_EN) begin
                model_clear(k);
                free_edge = e + ROWS + k + 2;
                busy_lo   = e;
                busy_hi   = e + ROWS + k - 1;
                exp_done.push_back('{obs: e + ROWS + k, lines: (k > 7) ? 7 : k});
            end else begin
                free_edge = e + 2;
                exp_done.push_back('{obs: e, lines: 0});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic wr(input int row, input int data, input bit merge);
        drive(1, row, data, merge, 0, 0, 0, 0);
    endtask
    task automatic rd(input int addr);
        drive(0, 0, 0, 0, 0, 0, 1, addr);
    endtask
    task automatic sweep();
        for (int r = 0; r < ROWS; r++) rd(r);
    endtask

    task automatic do_reset();
        @(negedge vga_clk);
        rst = 1'b1; wr_en = 1'b0; clear_req = 1'b0; wipe_req = 1'b0; rd_issue = 1'b0;
        if (busy_hi > cyc) busy_hi = cyc;
        for (int r = 0; r < ROWS; r++) board[r] = 0;
        free_edge = cyc + 3;
        @(negedge vga_clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge vga_clk);

        // Reset state, including out-of-range addresses
        sweep(); rd(25); rd(31);

        // Single full row
        wr(19, 'hFFF, 0); wr(18, 'h0F0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        idle(30); sweep();

        // Four full rows
        for (int r = 16; r < 20; r++) wr(r, 'hFFF, 0);
        wr(15, 'h801, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        idle(32); sweep();

        // Merge and one-cycle read latency; out-of-range write dropped
        wr(5, 'h0F0, 0);
        drive(1, 5, 'h00F, 1, 0, 0, 1, 5);
        rd(5);
        wr(20, 'hFFF, 0); rd(20); rd(5);

        // lines_cleared saturation
        for (int r = 10; r < 20; r++) wr(r, 'hFFF, 0);
        wr(9, 'h123, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        idle(40); sweep();

        // Writes and wipe during a pass are dropped
        wr(19, 'hFFF, 0); wr(18, 'h555, 0); wr(17, 'hFFF, 0); wr(16, 'h0AA, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        idle(2); wr(3, 'hABC, 0); idle(1);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        idle(1); wr(19, 'h777, 1);
        idle(35); sweep();

        // Reset in the middle of a pass
        wr(19, 'hFFF, 0); wr(10, 'h3C3, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        idle(6);
        do_reset();
        sweep();

        // Wipe of a populated board
        wr(0, 'h001, 0); wr(7, 'h7E7, 0); wr(19, 'hFFF, 0); wr(12, 'h800, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        idle(24); sweep();

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            int p;
            p = $urandom_range(0, 99);
            drive(p < 40, $urandom_range(0, 23),
                  ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4095) : FULL,
                  1'($urandom_range(0, 1)),
                  (p >= 40 && p < 46), (p == 46),
                  (p >= 50), $urandom_range(0, ROWS + 3));
        end
        idle(45); sweep(); idle(3);

        while (exp_done.size() > 0) begin
            done_t d;
            d = exp_done.pop_front();
            check("done_never", 64'(cyc), 64'(d.obs));
        end
        while (exp_rd.size() > 0) begin
            rd_t r;
            r = exp_rd.pop_front();
            check("read_never", 64'(r.addr), 64'hFFFF);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
